instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 28 ++
 rtl/instr_sequencer_mem.sv | 39 +++
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode, state-encoding and timing constants for the instruction
// sequencer and the control state machine it drives.
package instr_sequencer_pkg;

  localparam int unsigned INSTR_W = 11;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_DISP = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b101;
  localparam logic [2:0] OP_SUBI = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int unsigned EXEC_SHORT_DEF = 3;
  localparam int unsigned EXEC_LONG_DEF  = 5;

  function automatic logic is_short_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_DISP);
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store: DEPTH x 11-bit words, one write port and one registered,
// read-enabled read port whose output register is cleared by reset.
module instr_mem
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  // Array is deliberately not reset so the program survives rst.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Steps through a stored program, presenting each instruction with an
// execute strobe whose width depends on the opcode.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_SHORT = EXEC_SHORT_DEF,
  parameter int unsigned EXEC_LONG  = EXEC_LONG_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [3:0]          prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  input  logic [4:0]          prog_len,
  input  logic                start,
  output logic [INSTR_W-1:0]  instr,
  output logic                execute,
  output logic [3:0]          pc,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] CNT_SHORT = 3'(EXEC_SHORT - 1);
  localparam logic [2:0] CNT_LONG  = 3'(EXEC_LONG - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [4:0] len_q, len_d;
  logic [2:0] cnt_q, cnt_d;
  logic       launch_q, launch_d;
  logic       done_q, done_d;
  logic       rd_en;
  logic       mem_we;
  logic [4:0] pc_next;
  logic [4:0] len_clamped;

  assign busy        = launch_q || (state_q != ST_IDLE);
  assign len_clamped = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign pc_next     = {1'b0, pc_q} + 5'd1;
  assign mem_we      = prog_we && !busy && !rst;

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (4)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (rd_en),
    .raddr_i (pc_d),
    .rdata_o (instr)
  );

  // An accepted start spends one launch cycle in IDLE so the registered
  // read of word 0 is already on instr when FETCH begins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    launch_d = 1'b0;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch_q) begin
          rd_en   = 1'b1;
          state_d = ST_FETCH;
        end else if (start) begin
          len_d = len_clamped;
          if (len_clamped == 5'd0) begin
            done_d = 1'b1;
          end else begin
            pc_d     = '0;
            launch_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (instr[10:8] == OP_NOP) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_ISSUE;
          cnt_d   = is_short_op(instr[10:8]) ? CNT_SHORT : CNT_LONG;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_GAP: begin
        if (pc_next < len_q) begin
          pc_d    = pc_next[3:0];
          rd_en   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      launch_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      launch_q <= launch_d;
      done_q   <= done_d;
    end
  end

  assign execute = (state_q == ST_ISSUE);
  assign pc      = pc_q;
  assign done    = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: opcode table, directed multi-cycle sequences and
// randomized programs checked against a cycle-trace model of the sequencer.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic [10:0] instr;
  logic        execute;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  instr_sequencer #(
    .EXEC_SHORT (3),
    .EXEC_LONG  (5),
    .DEPTH      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .instr     (instr),
    .execute   (execute),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exec;
    logic [3:0]  pc;
    logic [10:0] instr;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic [10:0] word;
    int          exp_exec;
    int          exp_done_cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [10:0] model_mem [16];
  logic [10:0] m_instr;
  logic [3:0]  m_pc;
  obs_t        exp_q [$];

  int win_len [$];
  int win_pc [$];
  int done_cnt, done_cyc, first_exec, pc1_cyc, busy_at_done;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [10:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  function automatic int exec_cycles(input logic [10:0] w);
    case (w[10:8])
      3'b000, 3'b100: return 3;
      3'b101:         return 0;
      default:        return 5;
    endcase
  endfunction

  function automatic obs_t mk(input logic e, input logic [3:0] p, input logic [10:0] w,
                              input logic b, input logic d);
    obs_t o;
    o.exec = e; o.pc = p; o.instr = w; o.busy = b; o.done = d;
    return o;
  endfunction

  // Expected per-cycle trace from the cycle after the start edge; also
  // advances the model's view of the held pc/instr.
  function automatic void build(input int len_raw);
    int n;
    logic [10:0] w;
    exp_q.delete();
    n = (len_raw > 16) ? 16 : len_raw;
    if (n == 0) begin
      exp_q.push_back(mk(1'b0, m_pc, m_instr, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b0, m_pc, m_instr, 1'b0, 1'b0));
      return;
    end
    exp_q.push_back(mk(1'b0, 4'd0, m_instr, 1'b1, 1'b0));
    for (int i = 0; i < n; i++) begin
      w = model_mem[i];
      exp_q.push_back(mk(1'b0, 4'(i), w, 1'b1, 1'b0));
      for (int k = 0; k < exec_cycles(w); k++) exp_q.push_back(mk(1'b1, 4'(i), w, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, 4'(i), w, 1'b1, 1'b0));
    end
    w = model_mem[n-1];
    exp_q.push_back(mk(1'b0, 4'(n-1), w, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 4'(n-1), w, 1'b0, 1'b0));
    m_pc = 4'(n-1);
    m_instr = w;
  endfunction

  task automatic run_prog(input int len_raw, input string tag);
    obs_t act;
    build(len_raw);
    prog_len = 5'(len_raw); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      act = mk(execute, pc, instr, busy, done);
      chk($sformatf("%s len=%0d cyc=%0d {exec,pc,instr,busy,done}", tag, len_raw, i),
          32'(act), 32'(exp_q[i]));
      tick();
    end
  endtask

  task automatic measure(input int len_raw, input int max_cyc);
    bit in_win;
    win_len.delete(); win_pc.delete();
    done_cnt = 0; done_cyc = -1; first_exec = -1; pc1_cyc = 0; busy_at_done = -1;
    build(len_raw);
    prog_len = 5'(len_raw); start = 1'b1;
    tick();
    start = 1'b0;
    in_win = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (execute === 1'b1) begin
        if (!in_win) begin
          win_len.push_back(0);
          win_pc.push_back(int'(pc));
          if (first_exec < 0) first_exec = c;
        end
        win_len[win_len.size()-1] += 1;
      end
      in_win = (execute === 1'b1);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = int'(busy); end
      end
      if (busy === 1'b1 && pc === 4'd1) pc1_cyc++;
      tick();
    end
  endtask

  function automatic int wl(input int i);
    return (i < win_len.size()) ? win_len[i] : -1;
  endfunction

  function automatic int wp(input int i);
    return (i < win_pc.size()) ? win_pc[i] : -1;
  endfunction

  function automatic logic [10:0] fill_word(input int i);
    logic [2:0] op;
    op = (i % 3 == 0) ? 3'b000 : (i % 3 == 1) ? 3'b011 : 3'b100;
    return {op, 2'(i % 4), 2'((i + 1) % 4), 4'(i)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex, dn, sum, len;
    int exp_w [3];
    int exp_p [3];

    vecs[0] = '{11'b000_00_00_0001, 3, 6};
    vecs[1] = '{11'b001_10_00_0101, 5, 8};
    vecs[2] = '{11'b010_01_10_0000, 5, 8};
    vecs[3] = '{11'b011_00_01_0000, 5, 8};
    vecs[4] = '{11'b100_11_00_0000, 3, 6};
    vecs[5] = '{11'b101_00_00_0000, 0, 3};
    vecs[6] = '{11'b110_01_00_0111, 5, 8};
    vecs[7] = '{11'b111_10_00_1111, 5, 8};

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0; start = 1'b0;
    m_pc = '0; m_instr = '0;
    tick(); tick();
    chk("reset execute", 32'(execute), 32'd0);
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset done",    32'(done),    32'd0);
    chk("reset pc",      32'(pc),      32'd0);
    chk("reset instr",   32'(instr),   32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) write_word(4'(i), fill_word(i));

    // Single-instruction programs: window width and done timing per opcode.
    for (int v = 0; v < 8; v++) begin
      write_word(4'd0, vecs[v].word);
      measure(1, 14);
      sum = 0;
      foreach (win_len[i]) sum += win_len[i];
      chk($sformatf("vec%0d exec cycles", v), 32'(sum), 32'(vecs[v].exp_exec));
      chk($sformatf("vec%0d done cycle", v), 32'(done_cyc), 32'(vecs[v].exp_done_cyc));
      chk($sformatf("vec%0d instr held", v), 32'(instr), 32'(vecs[v].word));
    end

    write_word(4'd0, 11'b000_00_00_0001);
    measure(1, 12);
    chk("single windows",    32'(win_len.size()), 32'd1);
    chk("single width",      32'(wl(0)), 32'd3);
    chk("single pc",         32'(wp(0)), 32'd0);
    chk("single latency",    32'(first_exec), 32'd2);
    chk("single done cycle", 32'(done_cyc), 32'd6);
    chk("single busy@done",  32'(busy_at_done), 32'd0);
    chk("single done count", 32'(done_cnt), 32'd1);

    write_word(4'd0, 11'b000_00_00_0001);
    write_word(4'd1, 11'b000_01_00_0010);
    write_word(4'd2, 11'b011_00_01_0000);
    measure(3, 30);
    exp_w = '{3, 3, 5};
    exp_p = '{0, 1, 2};
    chk("prog3 windows", 32'(win_len.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("prog3 width%0d", i), 32'(wl(i)), 32'(exp_w[i]));
      chk($sformatf("prog3 pc%0d", i),    32'(wp(i)), 32'(exp_p[i]));
    end
    chk("prog3 done count", 32'(done_cnt), 32'd1);

    // Second start and a write while busy must both be dropped.
    build(3);
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    ex = 0; dn = 0;
    for (int c = 0; c < 45; c++) begin
      if (execute === 1'b1) ex++;
      if (done === 1'b1) dn++;
      if (c == 3) begin
        start = 1'b1; prog_len = 5'd1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'h7FF;
      end
      tick();
      if (c == 3) begin start = 1'b0; prog_we = 1'b0; end
    end
    chk("busy-ignore exec cycles", 32'(ex), 32'd11);
    chk("busy-ignore done count",  32'(dn), 32'd1);
    run_prog(3, "readback");

    write_word(4'd1, 11'b101_00_00_0000);
    measure(3, 30);
    chk("nop windows",    32'(win_len.size()), 32'd2);
    chk("nop pc first",   32'(wp(0)), 32'd0);
    chk("nop pc second",  32'(wp(1)), 32'd2);
    chk("nop pc1 cycles", 32'(pc1_cyc), 32'd2);
    chk("nop done count", 32'(done_cnt), 32'd1);

    measure(0, 4);
    chk("len0 done cycle", 32'(done_cyc), 32'd0);
    chk("len0 windows",    32'(win_len.size()), 32'd0);
    chk("len0 done count", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 16; i++) write_word(4'(i), fill_word(i));
    measure(20, 200);
    chk("clamp windows",    32'(win_len.size()), 32'd16);
    chk("clamp last pc",    32'(wp(15)), 32'd15);
    chk("clamp done count", 32'(done_cnt), 32'd1);

    // Reset in the 2nd addi execute cycle, with start and a write colliding.
    write_word(4'd0, 11'b111_11_00_0011);
    prog_len = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort exec before rst", 32'(execute), 32'd1);
    rst = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'b000_00_00_0001;
    tick();
    rst = 1'b0; start = 1'b0; prog_we = 1'b0;
    chk("abort execute", 32'(execute), 32'd0);
    chk("abort busy",    32'(busy),    32'd0);
    chk("abort pc",      32'(pc),      32'd0);
    chk("abort instr",   32'(instr),   32'd0);
    chk("abort done",    32'(done),    32'd0);
    tick();
    chk("abort no done", 32'(done),    32'd0);
    m_pc = '0; m_instr = '0;
    run_prog(1, "rerun");

    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) write_word(4'($urandom_range(0, 15)), 11'($urandom));
      len = (r % 5 == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 16));
      run_prog(len, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
